// File: rtl/element_pkg.sv
// -----------------------------------------------------------------------------
// element_pkg
// Shared definitions for the element_* debounce slice.
//   debounce_state_t      : FSM state encoding used by element_debouncer
//   DEFAULT_STABLE_CYCLES : default qualification window (samples)
// No ports (package).
// -----------------------------------------------------------------------------
package element_pkg;

   localparam int DEFAULT_STABLE_CYCLES = 4;

   // IDLE_* : output settled at that level, watching for a differing sample.
   // CHECK_*: qualifying a candidate new level; any contrary sample aborts.
   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      IDLE_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } debounce_state_t;

endpackage : element_pkg

// File: rtl/element_sync.sv
// -----------------------------------------------------------------------------
// element_sync
// Two-flop synchronizer bringing an asynchronous level into the clock domain.
// Only instantiated by element_debouncer when ELEMENT_DEBOUNCER_SYNC_EN is
// defined.
// Ports:
//   clock   in  : sampling clock, rising edge
//   reset_n in  : asynchronous active-low reset, clears both flops
//   data    in  : asynchronous level
//   out     out : synchronized level, two clock edges behind data
// -----------------------------------------------------------------------------
module element_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic data,
   output logic out
);

   logic meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         out  <= 1'b0;
      end else begin
         meta <= data;
         out  <= meta;
      end
   end

endmodule : element_sync

// File: rtl/element_debouncer.sv
// -----------------------------------------------------------------------------
// element_debouncer
// Debounces a bouncing switch/button level. A new level is accepted only after
// STABLE_CYCLES consecutive equal samples; shorter excursions are ignored.
//
// Parameters:
//   STABLE_CYCLES : consecutive samples needed to accept a new level (2..65535)
//
// Ports:
//   clock   in  : single clock, all state on the rising edge
//   reset_n in  : asynchronous active-low reset
//   data    in  : raw, possibly bouncing level
//   out     out : debounced level (registered)
//   rise    out : one-cycle pulse on out 0->1 (registered)
//   fall    out : one-cycle pulse on out 1->0 (registered)
//
// Configuration macro:
//   ELEMENT_DEBOUNCER_SYNC_EN : defined   -> data passes through element_sync
//                                            (+2 cycles latency)
//                               undefined -> data is sampled directly; the
//                                            caller guarantees it is already
//                                            synchronous to clock
//
// Latency from data change (set up before edge k) to out change:
//   edge k + STABLE_CYCLES - 1 without the synchronizer,
//   edge k + STABLE_CYCLES + 1 with it.
// -----------------------------------------------------------------------------
module element_debouncer
   import element_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic data,
   output logic out,
   output logic rise,
   output logic fall
);

   // Wide enough to hold STABLE_CYCLES; in practice it tops out at
   // STABLE_CYCLES-1 because reaching that value ends the window.
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] ONE        = CW'(1);

   logic            data_s;
   debounce_state_t state;
   logic [CW-1:0]   counter;

`ifdef ELEMENT_DEBOUNCER_SYNC_EN
   element_sync u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .data    (data),
      .out     (data_s)
   );
`else
   assign data_s = data;
`endif

   // The counter holds the number of differing samples already seen in the
   // current window, so the sample that arrives while counter==STABLE_CYCLES-1
   // is the STABLE_CYCLES-th one and commits the new level on this same edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE_LOW;
         counter <= '0;
         out     <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         // Pulses are single-cycle: cleared unless set below.
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (data_s) begin
                  state   <= CHECK_HIGH;
                  counter <= ONE;
               end
            end
            CHECK_HIGH: begin
               if (!data_s) begin
                  state   <= IDLE_LOW;
                  counter <= '0;
               end else if (counter == LAST_COUNT) begin
                  state   <= IDLE_HIGH;
                  counter <= '0;
                  out     <= 1'b1;
                  rise    <= 1'b1;
               end else begin
                  counter <= counter + ONE;
               end
            end
            IDLE_HIGH: begin
               if (!data_s) begin
                  state   <= CHECK_LOW;
                  counter <= ONE;
               end
            end
            CHECK_LOW: begin
               if (data_s) begin
                  state   <= IDLE_HIGH;
                  counter <= '0;
               end else if (counter == LAST_COUNT) begin
                  state   <= IDLE_LOW;
                  counter <= '0;
                  out     <= 1'b0;
                  fall    <= 1'b1;
               end else begin
                  counter <= counter + ONE;
               end
            end
            default: begin
               state   <= IDLE_LOW;
               counter <= '0;
               out     <= 1'b0;
            end
         endcase
      end
   end

endmodule : element_debouncer
